multicycle_control: RTL and testbench

- Parametrised multi-cycle successor to the single-cycle control decoder. Sequences each instruction through FETCH/DECODE/EXEC/MEM/WB states instead of decoding in one cycle.
- Stalls on a memory-ready handshake, resolves branches with the ALU zero flag, and halts on a HALT opcode.
- Sits between the instruction register/PC and the datapath; drives the same control names (branch, ldImmed, MemtoReg, MemWrite, RegWrite).

---
 rtl/multicycle_control.sv | 179 +++++++++++++++++
 tb/tb_multicycle_control.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control.sv
// multicycle_control: multi-cycle instruction sequencer.
// Steps each instruction through FETCH/DECODE/EXEC|MEM|BR/WB, stalls on
// mem_ready, resolves branches with the ALU zero flag, halts on HALT and
// drops into a sticky error state when a memory access times out.
// Optional feature macro: PERF_CNT_EN adds instr_count_o / cycle_count_o.
//
// state  | meaning
// IDLE   | waiting for start
// FETCH  | load instruction register
// DECODE | capture opcode, pick the execution path
// EXEC   | ALU / load-immediate operation
// MEM    | data memory access, waiting on mem_ready
// WB     | register-file write back, retire
// BR     | branch / jump resolution, retire
// DONE   | HALT retired, parked until Reset
// ERR    | memory timeout, parked until Reset
module multicycle_control #(
    parameter int unsigned OPW         = 3,
    parameter int unsigned OP_LDI      = 0,
    parameter int unsigned OP_BRZ      = 3,
    parameter int unsigned OP_JMP      = 5,
    parameter int unsigned OP_LD       = 6,
    parameter int unsigned OP_ST       = 7,
    parameter int unsigned OP_HALT     = 4,
    parameter int unsigned MEM_TIMEOUT = 15
) (
    input  logic           Clk_i,
    input  logic           Reset_i,
    input  logic           start_i,
    input  logic [OPW-1:0] opcode_i,
    input  logic           zero_i,
    input  logic           mem_ready_i,
    output logic           ir_load_o,
    output logic           pc_en_o,
    output logic           branch_o,
    output logic           ldImmed_o,
    output logic           MemRead_o,
    output logic           MemWrite_o,
    output logic           MemtoReg_o,
    output logic           RegWrite_o,
    output logic           done_o,
`ifdef PERF_CNT_EN
    output logic [31:0]    instr_count_o,
    output logic [31:0]    cycle_count_o,
`endif
    output logic           err_o
);

    localparam int CW = $clog2(MEM_TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_BR, S_DONE_ERR_PAD
    } unused_t;

    typedef enum logic [3:0] {
        ST_IDLE, ST_FETCH, ST_DECODE, ST_EXEC, ST_MEM, ST_WB, ST_BR, ST_DONE, ST_ERR
    } state_t;

    state_t         state_q, state_d;
    logic [OPW-1:0] op_q, op_d;
    logic [CW-1:0]  cnt_q, cnt_d;

    logic op_is_ldi, op_is_ld, op_is_st, op_is_brz, op_is_jmp;
    logic in_is_halt, in_is_mem, in_is_br;

    assign op_is_ldi  = (op_q == OPW'(OP_LDI));
    assign op_is_ld   = (op_q == OPW'(OP_LD));
    assign op_is_st   = (op_q == OPW'(OP_ST));
    assign op_is_brz  = (op_q == OPW'(OP_BRZ));
    assign op_is_jmp  = (op_q == OPW'(OP_JMP));
    assign in_is_halt = (opcode_i == OPW'(OP_HALT));
    assign in_is_mem  = (opcode_i == OPW'(OP_LD)) || (opcode_i == OPW'(OP_ST));
    assign in_is_br   = (opcode_i == OPW'(OP_BRZ)) || (opcode_i == OPW'(OP_JMP));

    // State, latched opcode and memory-wait counter registers.
    always_ff @(posedge Clk_i) begin
        if (Reset_i) begin
            state_q <= ST_IDLE;
            op_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic; the counter is cleared on the way into MEM so each
    // access gets a fresh MEM_TIMEOUT-cycle window.
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE:   if (start_i) state_d = ST_FETCH;
            ST_FETCH:  state_d = ST_DECODE;
            ST_DECODE: begin
                op_d  = opcode_i;
                cnt_d = '0;
                if (in_is_halt)     state_d = ST_DONE;
                else if (in_is_mem) state_d = ST_MEM;
                else if (in_is_br)  state_d = ST_BR;
                else                state_d = ST_EXEC;
            end
            ST_EXEC:   state_d = ST_WB;
            ST_MEM: begin
                // A ready arriving in the last allowed cycle still completes.
                if (mem_ready_i)
                    state_d = op_is_ld ? ST_WB : ST_FETCH;
                else if (cnt_q == CW'(MEM_TIMEOUT - 1))
                    state_d = ST_ERR;
                else
                    cnt_d = cnt_q + 1'b1;
            end
            ST_WB:     state_d = ST_FETCH;
            ST_BR:     state_d = ST_FETCH;
            ST_DONE:   state_d = ST_DONE;
            ST_ERR:    state_d = ST_ERR;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Moore output decode; everything is held low while Reset is asserted.
    always_comb begin
        ir_load_o  = 1'b0;
        pc_en_o    = 1'b0;
        branch_o   = 1'b0;
        ldImmed_o  = 1'b0;
        MemRead_o  = 1'b0;
        MemWrite_o = 1'b0;
        MemtoReg_o = 1'b0;
        RegWrite_o = 1'b0;
        done_o     = 1'b0;
        err_o      = 1'b0;
        if (!Reset_i) begin
            case (state_q)
                ST_FETCH: ir_load_o = 1'b1;
                ST_EXEC:  ldImmed_o = op_is_ldi;
                ST_MEM: begin
                    MemRead_o  = op_is_ld;
                    MemWrite_o = op_is_st;
                    pc_en_o    = op_is_st && mem_ready_i;
                end
                ST_WB: begin
                    RegWrite_o = 1'b1;
                    MemtoReg_o = op_is_ld;
                    ldImmed_o  = op_is_ldi;
                    pc_en_o    = 1'b1;
                end
                ST_BR: begin
                    pc_en_o  = 1'b1;
                    branch_o = op_is_jmp || (op_is_brz && zero_i);
                end
                ST_DONE:  done_o = 1'b1;
                ST_ERR:   err_o  = 1'b1;
                default:  ;
            endcase
        end
    end

`ifdef PERF_CNT_EN
    logic halt_retire;
    logic busy;
    assign halt_retire = (state_q == ST_DECODE) && (state_d == ST_DONE);
    assign busy = (state_q != ST_IDLE) && (state_q != ST_DONE) && (state_q != ST_ERR);

    // Retired-instruction and active-cycle counters, free-running wrap.
    always_ff @(posedge Clk_i) begin
        if (Reset_i) begin
            instr_count_o <= '0;
            cycle_count_o <= '0;
        end else begin
            if (pc_en_o || halt_retire) instr_count_o <= instr_count_o + 32'd1;
            if (busy)                   cycle_count_o <= cycle_count_o + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_multicycle_control.sv
module tb_multicycle_control;

    localparam int TO = 15;

    localparam logic [9:0] IRL = 10'h200, PCE = 10'h100, BRN = 10'h080, LDI = 10'h040,
                           MRD = 10'h020, MWR = 10'h010, M2R = 10'h008, RGW = 10'h004,
                           DON = 10'h002, ERR = 10'h001;

    logic       Clk_i = 1'b0;
    logic       Reset_i, start_i, zero_i, mem_ready_i;
    logic [2:0] opcode_i;
    logic ir_load_o, pc_en_o, branch_o, ldImmed_o, MemRead_o, MemWrite_o;
    logic MemtoReg_o, RegWrite_o, done_o, err_o;
`ifdef PERF_CNT_EN
    logic [31:0] instr_count_o, cycle_count_o;
`endif

    int checks = 0;
    int errors = 0;

    multicycle_control dut (
        .Clk_i(Clk_i), .Reset_i(Reset_i), .start_i(start_i), .opcode_i(opcode_i),
        .zero_i(zero_i), .mem_ready_i(mem_ready_i),
        .ir_load_o(ir_load_o), .pc_en_o(pc_en_o), .branch_o(branch_o),
        .ldImmed_o(ldImmed_o), .MemRead_o(MemRead_o), .MemWrite_o(MemWrite_o),
        .MemtoReg_o(MemtoReg_o), .RegWrite_o(RegWrite_o), .done_o(done_o),
`ifdef PERF_CNT_EN
        .instr_count_o(instr_count_o), .cycle_count_o(cycle_count_o),
`endif
        .err_o(err_o)
    );

    always #5 Clk_i = ~Clk_i;

    logic [9:0] vec;
    assign vec = {ir_load_o, pc_en_o, branch_o, ldImmed_o, MemRead_o, MemWrite_o,
                  MemtoReg_o, RegWrite_o, done_o, err_o};

    task automatic chk(input string tag, input int cyc, input logic [9:0] exp_v);
        checks++;
        assert (vec === exp_v) else begin
            errors++;
            $error("FAIL %s cyc %0d observed %b expected %b", tag, cyc, vec, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge Clk_i);
        #1;
    endtask

    // Reference model: the expected per-cycle output trace of one instruction,
    // starting in its FETCH cycle. w = MEM cycles with mem_ready low before it
    // rises; zf = 0/1 forces zero, 2 randomises it each cycle.
    task automatic run_instr(input string tag, input logic [2:0] op, input int w, input int zf);
        logic [9:0] ev[$];
        bit         mq[$];
        bit         zq[$];
        bit         z, ok;
        logic [9:0] acc;
        for (int i = 0; i < 2; i++) begin
            zq.push_back(zf == 2 ? 1'($urandom) : 1'(zf));
            mq.push_back(1'($urandom));
        end
        ev.push_back(IRL);
        ev.push_back(10'h000);
        case (op)
            3'd4: for (int i = 0; i < 10; i++) begin
                ev.push_back(DON); zq.push_back(1'($urandom)); mq.push_back(1'($urandom));
            end
            3'd3, 3'd5: begin
                z = (zf == 2) ? 1'($urandom) : 1'(zf);
                ev.push_back(PCE | ((op == 3'd5 || z) ? BRN : 10'h000));
                zq.push_back(z); mq.push_back(1'($urandom));
            end
            3'd6, 3'd7: begin
                acc = (op == 3'd6) ? MRD : MWR;
                ok  = 1'b0;
                for (int k = 0; k < TO; k++) begin
                    zq.push_back(1'($urandom));
                    if (k == w) begin
                        ev.push_back(acc | ((op == 3'd7) ? PCE : 10'h000));
                        mq.push_back(1'b1);
                        ok = 1'b1;
                        break;
                    end
                    ev.push_back(acc);
                    mq.push_back(1'b0);
                end
                if (!ok) begin
                    for (int i = 0; i < 5; i++) begin
                        ev.push_back(ERR); zq.push_back(1'($urandom)); mq.push_back(1'($urandom));
                    end
                end else if (op == 3'd6) begin
                    ev.push_back(RGW | M2R | PCE); zq.push_back(1'($urandom)); mq.push_back(1'($urandom));
                end
            end
            default: begin
                ev.push_back((op == 3'd0) ? LDI : 10'h000);
                ev.push_back(RGW | PCE | ((op == 3'd0) ? LDI : 10'h000));
                for (int i = 0; i < 2; i++) begin
                    zq.push_back(1'($urandom)); mq.push_back(1'($urandom));
                end
            end
        endcase
        for (int i = 0; i < ev.size(); i++) begin
            opcode_i    = op;
            zero_i      = zq[i];
            mem_ready_i = mq[i];
            start_i     = 1'($urandom);
            #1;
            chk(tag, i, ev[i]);
            tick();
        end
    endtask

    // Synchronous reset for one cycle, then start from IDLE into FETCH.
    task automatic restart(input string tag);
        Reset_i = 1'b1;
        start_i = 1'($urandom);
        #1;
        chk({tag, "_rst"}, 0, 10'h000);
        tick();
        Reset_i = 1'b0;
        start_i = 1'b0;
        #1;
        chk({tag, "_idle"}, 0, 10'h000);
        tick();
        chk({tag, "_idle_hold"}, 0, 10'h000);
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
    endtask

    initial begin
        logic [2:0] rop;
        Reset_i = 1'b1; start_i = 1'b1; opcode_i = '0; zero_i = 1'b0; mem_ready_i = 1'b0;
        #1;
        chk("reset_c0", 0, 10'h000);
        tick();
        chk("reset_c1", 1, 10'h000);
        tick();
        Reset_i = 1'b0;
        #1;
        chk("idle_after_reset", 0, 10'h000);
        tick();

        run_instr("alu_op2", 3'd2, 0, 2);
        run_instr("ldi", 3'd0, 0, 2);
        run_instr("ld_wait3", 3'd6, 3, 2);
        run_instr("brz_z0", 3'd3, 0, 0);
        run_instr("brz_z1", 3'd3, 0, 1);
        run_instr("jmp_z0", 3'd5, 0, 0);
        run_instr("st_ready0", 3'd7, 0, 2);
        run_instr("st_ready_last", 3'd7, TO - 1, 2);
        run_instr("ld_ready_last", 3'd6, TO - 1, 2);
        run_instr("st_timeout", 3'd7, TO, 2);

        restart("after_err");
        run_instr("halt", 3'd4, 0, 2);

        // Reset during MEM of a store: no write, no retire, back to IDLE.
        restart("after_halt");
        opcode_i = 3'd7; mem_ready_i = 1'b0;
        #1; chk("rm_fetch", 0, IRL); tick();
        #1; chk("rm_decode", 1, 10'h000); tick();
        #1; chk("rm_mem", 2, MWR); tick();
        Reset_i = 1'b1; mem_ready_i = 1'b1;
        #1; chk("rm_reset_cycle", 3, 10'h000); tick();
        Reset_i = 1'b0; start_i = 1'b0; mem_ready_i = 1'b0;
        #1; chk("rm_idle", 4, 10'h000); tick();
        #1; chk("rm_idle_hold", 5, 10'h000);
        start_i = 1'b1; tick(); start_i = 1'b0;

        for (int n = 0; n < 40; n++) begin
            rop = 3'($urandom_range(0, 7));
            if (rop == 3'd4) rop = 3'd1;
            run_instr("rand", rop, int'($urandom_range(0, 5)), 2);
        end
        run_instr("halt_end", 3'd4, 0, 2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
